// File: rtl/ctrl_pkg.sv
// Shared types and constants for the ID-stage main-control decoder.
package ctrl_pkg;

  // RV32I base opcodes (instr[6:0])
  typedef enum logic [6:0] {
    OPC_LOAD   = 7'b0000011,
    OPC_OPIMM  = 7'b0010011,
    OPC_AUIPC  = 7'b0010111,
    OPC_STORE  = 7'b0100011,
    OPC_OP     = 7'b0110011,
    OPC_LUI    = 7'b0110111,
    OPC_BRANCH = 7'b1100011,
    OPC_JALR   = 7'b1100111,
    OPC_JAL    = 7'b1101111,
    OPC_SYSTEM = 7'b1110011
  } opcode_e;

  // ALU operation class handed to the ALU-control stage
  localparam logic [1:0] ALU_OP_LOAD_STORE = 2'b00;
  localparam logic [1:0] ALU_OP_I_TYPE     = 2'b01;
  localparam logic [1:0] ALU_OP_B_TYPE     = 2'b10;
  localparam logic [1:0] ALU_OP_R_TYPE     = 2'b11;

  // SYSTEM funct3=000 immediates (instr[31:20])
  localparam logic [11:0] F12_ECALL  = 12'h000;
  localparam logic [11:0] F12_EBREAK = 12'h001;
  localparam logic [11:0] F12_WFI    = 12'h105;
  localparam logic [11:0] F12_MRET   = 12'h302;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_WFI_SLEEP = 2'd1,
    ST_SYS_DRAIN = 2'd2
  } state_e;

  // Datapath control word carried into EX
  typedef struct packed {
    logic       reg_write;
    logic       mem_write;
    logic       mem_to_reg;
    logic       branch;
    logic       alu_src;
    logic       jump;
    logic       lui;
    logic       auipc;
    logic       jal;
    logic       r_type;
    logic [1:0] alu_op;
    logic       csr_write;
    logic       csr_data_sel;
    logic       csr_to_reg;
    logic       is_csr;
    logic       is_mret;
    logic       is_ecall;
    logic       is_ebreak;
    logic       illegal;
  } ctrl_t;

endpackage

// File: rtl/ctrl_decode_comb.sv
// Purely combinational instruction -> control-word decoder, including illegal detection.
module ctrl_decode_comb
  import ctrl_pkg::*;
#(
  parameter bit EN_CSR = 1'b1
) (
  input  logic [31:0] instr,
  output ctrl_t       ctrl,
  output logic        is_wfi
);

  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [2:0]  funct3;
  logic [4:0]  rs1;
  logic [11:0] funct12;

  assign opcode  = instr[6:0];
  assign rd      = instr[11:7];
  assign funct3  = instr[14:12];
  assign rs1     = instr[19:15];
  assign funct12 = instr[31:20];

  // Decode opcode/funct fields; anything not recognised raises only the illegal flag
  always_comb begin
    ctrl   = '0;
    is_wfi = 1'b0;
    case (opcode)
      OPC_OP: begin
        ctrl.reg_write = 1'b1;
        ctrl.r_type    = 1'b1;
        ctrl.alu_op    = ALU_OP_R_TYPE;
      end
      OPC_OPIMM: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.alu_op    = ALU_OP_I_TYPE;
      end
      OPC_LOAD: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.alu_src    = 1'b1;
        ctrl.alu_op     = ALU_OP_LOAD_STORE;
      end
      OPC_STORE: begin
        ctrl.mem_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.alu_op    = ALU_OP_LOAD_STORE;
      end
      OPC_BRANCH: begin
        ctrl.branch = 1'b1;
        ctrl.alu_op = ALU_OP_B_TYPE;
      end
      OPC_JAL: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.jump      = 1'b1;
        ctrl.jal       = 1'b1;
      end
      OPC_JALR: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.jump      = 1'b1;
      end
      OPC_LUI: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.lui       = 1'b1;
      end
      OPC_AUIPC: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.auipc     = 1'b1;
      end
      OPC_SYSTEM: begin
        if (funct3 == 3'b000) begin
          // Privileged ops require rs1 and rd to be zero
          if (rs1 == 5'd0 && rd == 5'd0) begin
            case (funct12)
              F12_MRET:   ctrl.is_mret   = 1'b1;
              F12_ECALL:  ctrl.is_ecall  = 1'b1;
              F12_EBREAK: ctrl.is_ebreak = 1'b1;
              F12_WFI:    is_wfi         = 1'b1;
              default:    ctrl.illegal   = 1'b1;
            endcase
          end else begin
            ctrl.illegal = 1'b1;
          end
        end else if (funct3 == 3'b100) begin
          ctrl.illegal = 1'b1;
        end else if (!EN_CSR) begin
          ctrl.illegal = 1'b1;
        end else begin
          ctrl.is_csr       = 1'b1;
          ctrl.reg_write    = 1'b1;
          ctrl.csr_to_reg   = 1'b1;
          ctrl.csr_data_sel = funct3[2];
          // Set/clear forms with a zero source are pure reads
          ctrl.csr_write    = !(funct3[1] && rs1 == 5'd0);
        end
      end
      default: ctrl.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/sys_decode_ctrl.sv
// ID/EX control register with WFI-sleep / SYSTEM-drain sequencer around the combinational decoder.
module sys_decode_ctrl
  import ctrl_pkg::*;
#(
  parameter bit EN_CSR       = 1'b1,
  parameter bit EN_WFI       = 1'b1,
  parameter int DRAIN_CYCLES = 2,
  parameter int NUM_IRQ      = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               id_valid_i,
  input  logic [31:0]        instr_i,
  input  logic               stall_i,
  input  logic               flush_i,
  input  logic [NUM_IRQ-1:0] irq_pending_i,
  output logic               id_stall_o,
  output logic               ex_valid_o,
  output logic               reg_write_o,
  output logic               mem_write_o,
  output logic               mem_to_reg_o,
  output logic               branch_o,
  output logic               alu_src_o,
  output logic               jump_o,
  output logic               lui_o,
  output logic               auipc_o,
  output logic               jal_o,
  output logic               r_type_o,
  output logic [1:0]         alu_op_o,
  output logic               csr_write_o,
  output logic               csr_data_sel_o,
  output logic               csr_to_reg_o,
  output logic               is_csr_o,
  output logic               is_mret_o,
  output logic               is_ecall_o,
  output logic               is_ebreak_o,
  output logic               illegal_o
);

  localparam int CNT_W = $clog2(DRAIN_CYCLES + 1);

  ctrl_t            dec_ctrl;
  logic             dec_wfi;
  ctrl_t            ctrl_reg, ctrl_next;
  logic             valid_reg, valid_next;
  state_e           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             wake_pend_reg, wake_pend_next;
  logic             irq_any;

  ctrl_decode_comb #(
    .EN_CSR (EN_CSR)
  ) u_decode (
    .instr  (instr_i),
    .ctrl   (dec_ctrl),
    .is_wfi (dec_wfi)
  );

  assign irq_any = |irq_pending_i;

  // State, counter and ID/EX control register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= ST_RUN;
      cnt_reg       <= '0;
      ctrl_reg      <= '0;
      valid_reg     <= 1'b0;
      wake_pend_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      ctrl_reg      <= ctrl_next;
      valid_reg     <= valid_next;
      wake_pend_reg <= wake_pend_next;
    end
  end

  // Next-state logic: flush beats stall, stall freezes everything but remembers a wake request
  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    ctrl_next      = ctrl_reg;
    valid_next     = valid_reg;
    wake_pend_next = wake_pend_reg;
    if (flush_i) begin
      state_next     = ST_RUN;
      cnt_next       = '0;
      ctrl_next      = '0;
      valid_next     = 1'b0;
      wake_pend_next = 1'b0;
    end else if (stall_i) begin
      if (state_reg == ST_WFI_SLEEP && irq_any) begin
        wake_pend_next = 1'b1;
      end
    end else begin
      ctrl_next  = '0;
      valid_next = 1'b0;
      case (state_reg)
        ST_RUN: begin
          if (id_valid_i) begin
            ctrl_next  = dec_ctrl;
            valid_next = 1'b1;
            if (dec_ctrl.is_mret || dec_ctrl.is_ecall || dec_ctrl.is_ebreak) begin
              state_next = ST_SYS_DRAIN;
              cnt_next   = CNT_W'(DRAIN_CYCLES);
            end else if (dec_wfi && EN_WFI && !irq_any) begin
              state_next = ST_WFI_SLEEP;
            end
          end
        end
        ST_SYS_DRAIN: begin
          if (cnt_reg <= CNT_W'(1)) begin
            state_next = ST_RUN;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg - CNT_W'(1);
          end
        end
        ST_WFI_SLEEP: begin
          if (irq_any || wake_pend_reg) begin
            state_next     = ST_RUN;
            wake_pend_next = 1'b0;
          end
        end
        default: begin
          state_next = ST_RUN;
          cnt_next   = '0;
        end
      endcase
    end
  end

  assign id_stall_o     = (state_reg != ST_RUN);
  assign ex_valid_o     = valid_reg;
  assign reg_write_o    = ctrl_reg.reg_write;
  assign mem_write_o    = ctrl_reg.mem_write;
  assign mem_to_reg_o   = ctrl_reg.mem_to_reg;
  assign branch_o       = ctrl_reg.branch;
  assign alu_src_o      = ctrl_reg.alu_src;
  assign jump_o         = ctrl_reg.jump;
  assign lui_o          = ctrl_reg.lui;
  assign auipc_o        = ctrl_reg.auipc;
  assign jal_o          = ctrl_reg.jal;
  assign r_type_o       = ctrl_reg.r_type;
  assign alu_op_o       = ctrl_reg.alu_op;
  assign csr_write_o    = ctrl_reg.csr_write;
  assign csr_data_sel_o = ctrl_reg.csr_data_sel;
  assign csr_to_reg_o   = ctrl_reg.csr_to_reg;
  assign is_csr_o       = ctrl_reg.is_csr;
  assign is_mret_o      = ctrl_reg.is_mret;
  assign is_ecall_o     = ctrl_reg.is_ecall;
  assign is_ebreak_o    = ctrl_reg.is_ebreak;
  assign illegal_o      = ctrl_reg.illegal;

endmodule

// File: tb/tb_sys_decode_ctrl.sv
// Directed-vector bench for sys_decode_ctrl with default parameters.
module tb_sys_decode_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        id_valid_i;
  logic [31:0] instr_i;
  logic        stall_i;
  logic        flush_i;
  logic [3:0]  irq_pending_i;
  logic        id_stall_o, ex_valid_o;
  logic        reg_write_o, mem_write_o, mem_to_reg_o, branch_o, alu_src_o;
  logic        jump_o, lui_o, auipc_o, jal_o, r_type_o;
  logic [1:0]  alu_op_o;
  logic        csr_write_o, csr_data_sel_o, csr_to_reg_o, is_csr_o;
  logic        is_mret_o, is_ecall_o, is_ebreak_o, illegal_o;

  int errors = 0;
  int checks = 0;

  // Expected-word bit masks, packed in the order of obs below
  localparam logic [20:0] V    = 21'd1 << 20;
  localparam logic [20:0] RW   = 21'd1 << 19;
  localparam logic [20:0] MW   = 21'd1 << 18;
  localparam logic [20:0] MR   = 21'd1 << 17;
  localparam logic [20:0] BR   = 21'd1 << 16;
  localparam logic [20:0] AS   = 21'd1 << 15;
  localparam logic [20:0] JP   = 21'd1 << 14;
  localparam logic [20:0] LU   = 21'd1 << 13;
  localparam logic [20:0] AU   = 21'd1 << 12;
  localparam logic [20:0] JL   = 21'd1 << 11;
  localparam logic [20:0] RT   = 21'd1 << 10;
  localparam logic [20:0] AO1  = 21'd1 << 8;
  localparam logic [20:0] AO2  = 21'd2 << 8;
  localparam logic [20:0] AO3  = 21'd3 << 8;
  localparam logic [20:0] CW   = 21'd1 << 7;
  localparam logic [20:0] CDS  = 21'd1 << 6;
  localparam logic [20:0] CTR  = 21'd1 << 5;
  localparam logic [20:0] CSR  = 21'd1 << 4;
  localparam logic [20:0] MRT  = 21'd1 << 3;
  localparam logic [20:0] ECL  = 21'd1 << 2;
  localparam logic [20:0] EBK  = 21'd1 << 1;
  localparam logic [20:0] ILL  = 21'd1;

  localparam logic [31:0] I_ADD    = 32'h003100B3;
  localparam logic [31:0] I_CSRRS  = 32'h300022F3;
  localparam logic [31:0] I_CSRRWI = 32'h3002D2F3;
  localparam logic [31:0] I_ADDI   = 32'h00100093;
  localparam logic [31:0] I_LW     = 32'h00012083;
  localparam logic [31:0] I_SW     = 32'h00112023;
  localparam logic [31:0] I_BEQ    = 32'h00208463;
  localparam logic [31:0] I_JAL    = 32'h008000EF;
  localparam logic [31:0] I_JALR   = 32'h000100E7;
  localparam logic [31:0] I_LUI    = 32'h000010B7;
  localparam logic [31:0] I_AUIPC  = 32'h00001097;
  localparam logic [31:0] I_MRET   = 32'h30200073;
  localparam logic [31:0] I_ECALL  = 32'h00000073;
  localparam logic [31:0] I_EBREAK = 32'h00100073;
  localparam logic [31:0] I_WFI    = 32'h10500073;

  logic [20:0] obs;
  assign obs = {ex_valid_o, reg_write_o, mem_write_o, mem_to_reg_o, branch_o, alu_src_o,
                jump_o, lui_o, auipc_o, jal_o, r_type_o, alu_op_o, csr_write_o,
                csr_data_sel_o, csr_to_reg_o, is_csr_o, is_mret_o, is_ecall_o,
                is_ebreak_o, illegal_o};

  sys_decode_ctrl dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .id_valid_i     (id_valid_i),
    .instr_i        (instr_i),
    .stall_i        (stall_i),
    .flush_i        (flush_i),
    .irq_pending_i  (irq_pending_i),
    .id_stall_o     (id_stall_o),
    .ex_valid_o     (ex_valid_o),
    .reg_write_o    (reg_write_o),
    .mem_write_o    (mem_write_o),
    .mem_to_reg_o   (mem_to_reg_o),
    .branch_o       (branch_o),
    .alu_src_o      (alu_src_o),
    .jump_o         (jump_o),
    .lui_o          (lui_o),
    .auipc_o        (auipc_o),
    .jal_o          (jal_o),
    .r_type_o       (r_type_o),
    .alu_op_o       (alu_op_o),
    .csr_write_o    (csr_write_o),
    .csr_data_sel_o (csr_data_sel_o),
    .csr_to_reg_o   (csr_to_reg_o),
    .is_csr_o       (is_csr_o),
    .is_mret_o      (is_mret_o),
    .is_ecall_o     (is_ecall_o),
    .is_ebreak_o    (is_ebreak_o),
    .illegal_o      (illegal_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_word(input string tag, input logic [20:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: word got %h expected %h", tag, obs, exp);
    end
    $display("check %s: word=%h stall=%b", tag, obs, id_stall_o);
  endtask

  task automatic chk_stall(input string tag, input logic exp);
    checks++;
    assert (id_stall_o === exp) else begin
      errors++;
      $error("FAIL %s: id_stall got %b expected %b", tag, id_stall_o, exp);
    end
  endtask

  task automatic issue(input string tag, input logic [31:0] ins, input logic [20:0] exp);
    instr_i    = ins;
    id_valid_i = 1'b1;
    step();
    chk_word(tag, exp);
    chk_stall({tag, "_stall"}, 1'b0);
  endtask

  initial begin
    reset_n       = 1'b0;
    id_valid_i    = 1'b0;
    instr_i       = 32'h0;
    stall_i       = 1'b0;
    flush_i       = 1'b0;
    irq_pending_i = 4'h0;
    repeat (3) step();
    chk_word("reset", 21'd0);
    chk_stall("reset_stall", 1'b0);
    reset_n = 1'b1;

    // Base opcodes and CSR forms
    issue("add",    I_ADD,    V | RW | RT | AO3);
    issue("csrrs",  I_CSRRS,  V | RW | CTR | CSR);
    issue("csrrwi", I_CSRRWI, V | RW | CTR | CSR | CW | CDS);
    issue("addi",   I_ADDI,   V | RW | AS | AO1);
    issue("lw",     I_LW,     V | RW | MR | AS);
    issue("sw",     I_SW,     V | MW | AS);
    issue("beq",    I_BEQ,    V | BR | AO2);
    issue("jal",    I_JAL,    V | RW | AS | JP | JL);
    issue("jalr",   I_JALR,   V | RW | AS | JP);
    issue("lui",    I_LUI,    V | RW | AS | LU);
    issue("auipc",  I_AUIPC,  V | RW | AS | AU);
    issue("ill_zero", 32'h00000000, V | ILL);
    issue("ill_f3_100", 32'h0000C073, V | ILL);

    // Bubble when no valid instruction
    id_valid_i = 1'b0;
    step();
    chk_word("bubble", 21'd0);

    // MRET followed by a two-cycle drain; fetch keeps presenting ADD
    instr_i    = I_MRET;
    id_valid_i = 1'b1;
    step();
    chk_word("mret", V | MRT);
    chk_stall("mret_stall", 1'b1);
    instr_i = I_ADD;
    step();
    chk_word("drain1", 21'd0);
    chk_stall("drain1_stall", 1'b1);
    step();
    chk_word("drain2", 21'd0);
    chk_stall("drain_done_stall", 1'b0);
    issue("add_after_drain", I_ADD, V | RW | RT | AO3);

    // WFI with no interrupt pending: sleep until irq[2]
    instr_i = I_WFI;
    step();
    chk_word("wfi", V);
    chk_stall("wfi_stall", 1'b1);
    for (int i = 0; i < 10; i++) begin
      step();
      chk_word("sleep", 21'd0);
      chk_stall("sleep_stall", 1'b1);
    end
    instr_i       = I_ADD;
    irq_pending_i = 4'b0100;
    step();
    chk_word("wake", 21'd0);
    chk_stall("wake_stall", 1'b0);
    irq_pending_i = 4'b0000;
    issue("add_after_wake", I_ADD, V | RW | RT | AO3);

    // WFI with an interrupt already pending stays in RUN
    irq_pending_i = 4'b0001;
    issue("wfi_pending", I_WFI, V);
    irq_pending_i = 4'b0000;
    issue("add_after_wfi", I_ADD, V | RW | RT | AO3);

    // ECALL, then stall holds the drain, then flush under stall clears it
    instr_i = I_ECALL;
    step();
    chk_word("ecall", V | ECL);
    chk_stall("ecall_stall", 1'b1);
    stall_i = 1'b1;
    step();
    chk_word("held", V | ECL);
    chk_stall("held_stall", 1'b1);
    flush_i = 1'b1;
    step();
    chk_word("flush", 21'd0);
    chk_stall("flush_stall", 1'b0);
    flush_i = 1'b0;
    stall_i = 1'b0;
    issue("add_after_flush", I_ADD, V | RW | RT | AO3);

    // EBREAK then asynchronous reset mid-drain
    instr_i = I_EBREAK;
    step();
    chk_word("ebreak", V | EBK);
    chk_stall("ebreak_stall", 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    chk_word("async_reset", 21'd0);
    chk_stall("async_reset_stall", 1'b0);
    reset_n = 1'b1;
    issue("add_after_reset", I_ADD, V | RW | RT | AO3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
